debug_dump_sender: RTL

Downstream of the data path and upstream of the debug UART transmitter; run by the debug unit when the program halts or after each step.
On a start pulse it snapshots the PC, then reads all 32 register-bank words and all 128 data-memory bytes through the data path's debug read ports.
It streams the result as a fixed 260-byte frame, one byte per UART tx handshake.

---
 rtl/debug_pkg.sv | 35 +++
 rtl/debug_tx_byte_sender.sv | 59 +++++
 rtl/debug_dump_sender.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared widths, frame layout and FSM encodings for the debug dump
// Shared with the debug unit and the host-side dump parser.
// No ports: package of localparams and typedefs only.
package debug_pkg;

  localparam int BYTE        = 8;
  localparam int DWORD       = 32;
  localparam int ADDR        = 7;
  localparam int RB_ADDR     = 5;
  localparam int N_REGS      = 32;
  localparam int N_MEM_BYTES = 128;
  localparam int FRAME_BYTES = 4 + 4 * N_REGS + N_MEM_BYTES;

  // Terminal counts are compared before incrementing, so counters never wrap.
  localparam logic [RB_ADDR-1:0] LAST_REG = RB_ADDR'(N_REGS - 1);
  localparam logic [ADDR-1:0]    LAST_MEM = ADDR'(N_MEM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RB_ADDR  = 3'd1,
    ST_RB_READ  = 3'd2,
    ST_DM_ADDR  = 3'd3,
    ST_DM_READ  = 3'd4,
    ST_TX_START = 3'd5,
    ST_TX_WAIT  = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_PC = 2'd0,
    PH_RB = 2'd1,
    PH_DM = 2'd2
  } phase_t;

endpackage

// File: rtl/debug_tx_byte_sender.sv
// rtl/debug_tx_byte_sender.sv - serialises a loaded word MSB-first over the UART tx handshake
// Ports:
//   clock, rst_n     : clock, asynchronous active-low reset
//   load             : capture word/count and start sending (ignored state-wise by caller)
//   word, count      : word to send (MSB byte first) and number of bytes after the first
//   tx_done          : UART done tick, only honoured while waiting on a byte
//   tx_data          : current byte (top of shift register)
//   tx_start         : one-cycle pulse per byte
//   word_sent        : combinational, high on the cycle the last byte's tx_done is taken
module debug_tx_byte_sender
  import debug_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DWORD-1:0] word,
  input  logic [1:0]       count,
  input  logic             tx_done,
  output logic [BYTE-1:0]  tx_data,
  output logic             tx_start,
  output logic             word_sent
);

  logic [DWORD-1:0] shift;
  logic [1:0]       bytes_left;
  logic             active;
  logic             waiting;

  // Waiting for the UART = handshake in progress and the start pulse already issued.
  assign waiting   = active & ~tx_start;
  assign word_sent = waiting & tx_done & (bytes_left == 2'd0);
  assign tx_data   = shift[DWORD-1 -: BYTE];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      bytes_left <= '0;
      active     <= 1'b0;
      tx_start   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (load) begin
        shift      <= word;
        bytes_left <= count;
        active     <= 1'b1;
        tx_start   <= 1'b1;
      end else if (waiting && tx_done) begin
        if (bytes_left != 2'd0) begin
          shift      <= {shift[DWORD-BYTE-1:0], {BYTE{1'b0}}};
          bytes_left <= bytes_left - 2'd1;
          tx_start   <= 1'b1;
        end else begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/debug_dump_sender.sv
// rtl/debug_dump_sender.sv - dumps PC, register bank and data memory as a 260-byte UART frame
// Ports:
//   i_clock, i_reset          : clock, asynchronous active-low reset
//   i_start                   : one-cycle dump request, honoured only when idle
//   i_pc_value                : PC, snapshotted at start
//   i_rb_data, i_dm_data      : debug read data, valid one cycle after address+enable
//   i_tx_done                 : UART tx done tick
//   o_rb_addr/o_rb_read_enable: register-bank debug read port
//   o_dm_addr/o_dm_read_enable: data-memory debug read port
//   o_tx_data, o_tx_start     : byte to UART and its one-cycle start
//   o_busy, o_done            : dump in progress, end-of-frame pulse
module debug_dump_sender
  import debug_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [DWORD-1:0]   i_pc_value,
  input  logic [DWORD-1:0]   i_rb_data,
  input  logic [BYTE-1:0]    i_dm_data,
  input  logic               i_tx_done,
  output logic [RB_ADDR-1:0] o_rb_addr,
  output logic               o_rb_read_enable,
  output logic [ADDR-1:0]    o_dm_addr,
  output logic               o_dm_read_enable,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  state_t             state;
  phase_t             phase;
  logic [RB_ADDR-1:0] reg_cnt;
  logic [ADDR-1:0]    mem_cnt;

  logic               load;
  logic [DWORD-1:0]   load_word;
  logic [1:0]         load_count;
  logic               word_sent;

  // The sender loads on the same edge that leaves IDLE or a *_READ state,
  // which is what makes the first tx_start appear one cycle after the start edge.
  always_comb begin
    load       = 1'b0;
    load_word  = i_pc_value;
    load_count = 2'd3;
    case (state)
      ST_IDLE:    load = i_start;
      ST_RB_READ: begin
        load      = 1'b1;
        load_word = i_rb_data;
      end
      ST_DM_READ: begin
        load       = 1'b1;
        load_word  = {i_dm_data, {(DWORD-BYTE){1'b0}}};
        load_count = 2'd0;
      end
      default: ;
    endcase
  end

  debug_tx_byte_sender u_sender (
    .clock     (i_clock),
    .rst_n     (i_reset),
    .load      (load),
    .word      (load_word),
    .count     (load_count),
    .tx_done   (i_tx_done),
    .tx_data   (o_tx_data),
    .tx_start  (o_tx_start),
    .word_sent (word_sent)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= ST_IDLE;
      phase            <= PH_PC;
      reg_cnt          <= '0;
      mem_cnt          <= '0;
      o_rb_addr        <= '0;
      o_rb_read_enable <= 1'b0;
      o_dm_addr        <= '0;
      o_dm_read_enable <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            phase   <= PH_PC;
            reg_cnt <= '0;
            mem_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= ST_TX_START;
          end
        end
        ST_TX_START: state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (word_sent) begin
            case (phase)
              PH_PC: begin
                reg_cnt          <= '0;
                o_rb_addr        <= '0;
                o_rb_read_enable <= 1'b1;
                phase            <= PH_RB;
                state            <= ST_RB_ADDR;
              end
              PH_RB: begin
                if (reg_cnt == LAST_REG) begin
                  mem_cnt          <= '0;
                  o_dm_addr        <= '0;
                  o_dm_read_enable <= 1'b1;
                  phase            <= PH_DM;
                  state            <= ST_DM_ADDR;
                end else begin
                  reg_cnt          <= reg_cnt + 1'b1;
                  o_rb_addr        <= reg_cnt + 1'b1;
                  o_rb_read_enable <= 1'b1;
                  state            <= ST_RB_ADDR;
                end
              end
              PH_DM: begin
                if (mem_cnt == LAST_MEM) begin
                  o_done <= 1'b1;
                  state  <= ST_DONE;
                end else begin
                  mem_cnt          <= mem_cnt + 1'b1;
                  o_dm_addr        <= mem_cnt + 1'b1;
                  o_dm_read_enable <= 1'b1;
                  state            <= ST_DM_ADDR;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if (i_tx_done) begin
            state <= ST_TX_START;
          end
        end
        ST_RB_ADDR: state <= ST_RB_READ;
        ST_RB_READ: begin
          o_rb_read_enable <= 1'b0;
          state            <= ST_TX_START;
        end
        ST_DM_ADDR: state <= ST_DM_READ;
        ST_DM_READ: begin
          o_dm_read_enable <= 1'b0;
          state            <= ST_TX_START;
        end
        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
